// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared definitions for the program memory slice.
//   state_e  - loader state encoding (RUN / LOAD)
//   OP_NOP   - opcode returned for unwritten or out-of-range fetches
//   OP_HALT  - halt opcode, commonly the last word of a loaded program
package prog_mem_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HALT = 8'hF0;

endpackage

// File: rtl/prog_mem_if.sv
// prog_mem_if: load and fetch bus of the program memory.
//   master - drives ld_start/ld_base/ld_valid/ld_data/ld_done and if_req/if_addr;
//            observes ld_ovf, busy, if_ready, if_valid, if_data, if_err
//   slave  - the memory side, directions mirrored
interface prog_mem_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_done;
    logic              ld_ovf;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_valid;
    logic [DATA_W-1:0] if_data;
    logic              if_err;
    logic              busy;

    modport master (
        output ld_start, ld_base, ld_valid, ld_data, ld_done, if_req, if_addr,
        input  ld_ovf, if_ready, if_valid, if_data, if_err, busy
    );

    modport slave (
        input  ld_start, ld_base, ld_valid, ld_data, ld_done, if_req, if_addr,
        output ld_ovf, if_ready, if_valid, if_data, if_err, busy
    );
endinterface

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: RUN/LOAD state machine, load pointer and sticky overflow flag.
//   clk, rst       - clock, asynchronous active-high reset
//   ld_start_i     - enter/restart LOAD, pointer := ld_base_i mod DEPTH, clear overflow
//   ld_base_i      - burst base address
//   ld_valid_i     - write strobe for the current pointer
//   ld_done_i      - leave LOAD (ignored when ld_start_i is also high)
//   busy_o         - high while in LOAD
//   ld_ovf_o       - pointer wrapped past DEPTH-1 since the last ld_start_i
//   wr_en_o        - memory write enable this cycle
//   wr_idx_o       - memory write index
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start_i,
    input  logic [ADDR_W-1:0] ld_base_i,
    input  logic              ld_valid_i,
    input  logic              ld_done_i,
    output logic              busy_o,
    output logic              ld_ovf_o,
    output logic              wr_en_o,
    output logic [IDX_W-1:0]  wr_idx_o
);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (ld_start_i) begin
            // ld_start has priority over ld_done and over any write in the same cycle
            state_q <= ST_LOAD;
            ptr_q   <= ADDR_W'({1'b0, ld_base_i} % (ADDR_W+1)'(DEPTH));
            ovf_q   <= 1'b0;
        end else if (state_q == ST_LOAD) begin
            if (ld_valid_i) begin
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    ptr_q <= '0;
                    ovf_q <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                end
            end
            if (ld_done_i) begin
                state_q <= ST_RUN;
            end
        end
    end

    assign busy_o   = (state_q == ST_LOAD);
    assign ld_ovf_o = ovf_q;
    assign wr_en_o  = (state_q == ST_LOAD) && ld_valid_i && !ld_start_i;
    // ptr_q never exceeds DEPTH-1, so the low bits are a valid array index
    assign wr_idx_o = ptr_q[IDX_W-1:0];

endmodule

// File: rtl/prog_mem.sv
// prog_mem: loadable program memory with a single-cycle fetch port.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - prog_mem_if.slave: load burst (ld_*), fetch (if_*), busy, ld_ovf
// Words never written since reset read as NOP_WORD; fetch addresses >= DEPTH
// read as NOP_WORD with if_err set. Fetches are accepted only in RUN.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(OP_NOP)
) (
    input  logic       clk,
    input  logic       rst,
    prog_mem_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  wbit_q;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              busy;
    logic              fetch_acc;
    logic              in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic              if_valid_q;
    logic              if_err_q;
    logic [DATA_W-1:0] if_data_q;

    prog_mem_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .ld_start_i (bus.ld_start),
        .ld_base_i  (bus.ld_base),
        .ld_valid_i (bus.ld_valid),
        .ld_done_i  (bus.ld_done),
        .busy_o     (busy),
        .ld_ovf_o   (bus.ld_ovf),
        .wr_en_o    (wr_en),
        .wr_idx_o   (wr_idx)
    );

    // Array contents are deliberately not reset; the written bits gate reads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbit_q <= '0;
        end else if (wr_en) begin
            wbit_q[wr_idx] <= 1'b1;
        end
    end

    assign fetch_acc = bus.if_req && !busy;
    assign in_range  = ({1'b0, bus.if_addr} < (ADDR_W+1)'(DEPTH));
    assign rd_idx    = bus.if_addr[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            if_data_q  <= NOP_WORD;
        end else if (fetch_acc) begin
            if_valid_q <= 1'b1;
            if_err_q   <= !in_range;
            if_data_q  <= (in_range && wbit_q[rd_idx]) ? mem_q[rd_idx] : NOP_WORD;
        end else begin
            // if_data keeps its last value when no response is issued
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
        end
    end

    assign bus.if_ready = !busy;
    assign bus.busy     = busy;
    assign bus.if_valid = if_valid_q;
    assign bus.if_err   = if_err_q;
    assign bus.if_data  = if_data_q;

endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: directed self-checking bench for prog_mem (ADDR_W=9, DEPTH=256).
module tb_prog_mem;
    import prog_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0] prog [6];

    prog_mem_if #(.DATA_W(8), .ADDR_W(9)) bus ();

    prog_mem #(
        .DATA_W   (8),
        .ADDR_W   (9),
        .DEPTH    (256),
        .NOP_WORD (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int unsigned addr, input logic [7:0] exp_data, input logic exp_err,
                         input string tag);
        bus.if_req  = 1'b1;
        bus.if_addr = 9'(addr);
        tick();
        chk({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
        chk({tag, "_data"},  32'(bus.if_data),  32'(exp_data));
        chk({tag, "_err"},   32'(bus.if_err),   32'(exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prog[0] = 8'hA3; prog[1] = 8'h91; prog[2] = 8'hA5;
        prog[3] = 8'h11; prog[4] = 8'h00; prog[5] = OP_HALT;
        bus.ld_start = 1'b0; bus.ld_base = '0; bus.ld_valid = 1'b0;
        bus.ld_data  = '0;   bus.ld_done = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_busy",  32'(bus.busy),     32'd0);
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_err",   32'(bus.if_err),   32'd0);
        chk("rst_data",  32'(bus.if_data),  32'h00);
        chk("rst_ovf",   32'(bus.ld_ovf),   32'd0);
        chk("rst_ready", 32'(bus.if_ready), 32'd1);
        tick(); tick();
        rst = 1'b0;

        // Fetches with nothing loaded, including out of range
        fetch(9, 8'h00, 1'b0, "unwr9");
        fetch(300, 8'h00, 1'b1, "oor300");
        bus.if_req = 1'b0;
        tick();
        chk("idle_valid", 32'(bus.if_valid), 32'd0);
        chk("idle_err",   32'(bus.if_err),   32'd0);

        // Load burst at base 0 with if_req held high throughout
        bus.ld_start = 1'b1; bus.ld_base = 9'd0;
        tick();
        bus.ld_start = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 9'd0;
        chk("ld_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("ld_ready", 32'(bus.if_ready), 32'd0);
            bus.ld_valid = 1'b1; bus.ld_data = prog[i];
            tick();
            chk("ld_busy_w", 32'(bus.busy),     32'd1);
            chk("ld_novalid", 32'(bus.if_valid), 32'd0);
        end
        bus.ld_valid = 1'b0; bus.ld_done = 1'b1;
        chk("exit_ready", 32'(bus.if_ready), 32'd0);
        tick();
        bus.ld_done = 1'b0;
        chk("exit_busy",  32'(bus.busy),     32'd0);
        chk("exit_valid", 32'(bus.if_valid), 32'd0);
        chk("run_ready",  32'(bus.if_ready), 32'd1);

        // Back-to-back fetches 0..5
        for (int i = 0; i < 6; i++) begin
            fetch(i, prog[i], 1'b0, "b2b");
        end
        bus.if_req = 1'b0;
        tick();
        chk("hold_valid", 32'(bus.if_valid), 32'd0);
        chk("hold_data",  32'(bus.if_data),  32'hF0);

        // Wrap from 255 to 0 sets the sticky overflow flag
        bus.ld_start = 1'b1; bus.ld_base = 9'd254;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 8'h11; tick();
        chk("wrap_ovf0", 32'(bus.ld_ovf), 32'd0);
        bus.ld_data = 8'h22; tick();
        chk("wrap_ovf1", 32'(bus.ld_ovf), 32'd1);
        bus.ld_data = 8'h33; tick();
        bus.ld_valid = 1'b0; bus.ld_done = 1'b1; tick();
        bus.ld_done = 1'b0;
        chk("wrap_ovf_run", 32'(bus.ld_ovf), 32'd1);
        fetch(254, 8'h11, 1'b0, "wrap254");
        fetch(255, 8'h22, 1'b0, "wrap255");
        fetch(0,   8'h33, 1'b0, "wrap0");
        bus.if_req = 1'b0;
        chk("wrap_ovf_keep", 32'(bus.ld_ovf), 32'd1);

        // Base 300 maps to 44; write together with done
        bus.ld_start = 1'b1; bus.ld_base = 9'd300;
        tick();
        bus.ld_start = 1'b0;
        chk("ovf_clr", 32'(bus.ld_ovf), 32'd0);
        bus.ld_valid = 1'b1; bus.ld_done = 1'b1; bus.ld_data = 8'h5A;
        tick();
        bus.ld_valid = 1'b0; bus.ld_done = 1'b0;
        chk("mod_busy", 32'(bus.busy), 32'd0);
        fetch(44, 8'h5A, 1'b0, "mod44");
        bus.if_req = 1'b0;

        // Reset in the middle of a burst after two writes
        bus.ld_start = 1'b1; bus.ld_base = 9'd0;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 8'hAA; tick();
        bus.ld_data = 8'hBB; tick();
        bus.ld_valid = 1'b0;
        chk("mid_busy_pre", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy",  32'(bus.busy),     32'd0);
        chk("ar_valid", 32'(bus.if_valid), 32'd0);
        chk("ar_data",  32'(bus.if_data),  32'h00);
        chk("ar_ready", 32'(bus.if_ready), 32'd1);
        #1 rst = 1'b0;
        fetch(0,   8'h00, 1'b0, "post0");
        fetch(1,   8'h00, 1'b0, "post1");
        fetch(254, 8'h00, 1'b0, "post254");
        bus.if_req = 1'b0;

        // Single-cycle write+done of HALT at 5, fetched right after
        bus.ld_start = 1'b1; bus.ld_base = 9'd5;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_done = 1'b1; bus.ld_data = OP_HALT;
        tick();
        bus.ld_valid = 1'b0; bus.ld_done = 1'b0;
        fetch(5, OP_HALT, 1'b0, "halt5");
        bus.if_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter DATA_W, default 8, instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8, fetch/load address width in bits.
REQ-003 Parameter DEPTH, default 256, number of stored words, range 2..2**ADDR_W.
REQ-004 Parameter NOP_WORD, default 8'h00, word returned for unwritten or out-of-range addresses.
REQ-005 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, asynchronous, active-high reset.
REQ-007 Port ld_start, input, 1, one-cycle pulse; enter LOAD and set load pointer to ld_base.
REQ-008 Port ld_base, input, ADDR_W, first address of a load burst, sampled with ld_start.
REQ-009 Port ld_valid, input, 1, ld_data is to be written at the load pointer this cycle.
REQ-010 Port ld_data, input, DATA_W, word to be written.
REQ-011 Port ld_done, input, 1, end of load burst.
REQ-012 Port ld_ovf, output, 1, sticky flag: load pointer wrapped past DEPTH-1.
REQ-013 Port if_req, input, 1, fetch request.
REQ-014 Port if_addr, input, ADDR_W, fetch address, sampled with if_req.
REQ-015 Port if_ready, output, 1, high when a fetch request is accepted this cycle.
REQ-016 Port if_valid, output, 1, if_data holds a fetch response this cycle.
REQ-017 Port if_data, output, DATA_W, fetched instruction word.
REQ-018 Port if_err, output, 1, qualifies if_valid: fetch address was >= DEPTH.
REQ-019 Port busy, output, 1, high while in LOAD.

Function
REQ-020 State machine SHALL have two states, RUN and LOAD; reset state SHALL be RUN.
REQ-021 RUN -> LOAD SHALL occur on ld_start; LOAD -> RUN SHALL occur on ld_done without ld_start.
REQ-022 ld_start in LOAD SHALL reload the pointer from ld_base and remain in LOAD.
REQ-023 ld_start and ld_done in the same cycle SHALL leave the block in LOAD (ld_start wins).
REQ-024 In LOAD, ld_valid SHALL write ld_data to mem[ptr], set the word's written bit, and increment ptr.
REQ-025 Pointer increment from DEPTH-1 SHALL wrap to 0 and set ld_ovf; ld_ovf SHALL clear only on the next ld_start or on reset.
REQ-026 ld_valid together with ld_done SHALL perform the write, then return to RUN.
REQ-027 ld_valid in RUN, or ld_done in RUN, SHALL be ignored.
REQ-028 ld_base >= DEPTH SHALL be taken modulo DEPTH.
REQ-029 if_ready SHALL equal (state == RUN) and SHALL be combinational.
REQ-030 A fetch accepted in cycle N (if_req and if_ready) SHALL produce if_valid = 1 in cycle N+1 with registered if_data; latency is exactly 1 cycle.
REQ-031 Back-to-back fetches SHALL sustain one response per cycle.
REQ-032 if_data SHALL be mem[if_addr] if written, else NOP_WORD; if_addr >= DEPTH SHALL give NOP_WORD with if_err = 1.
REQ-033 A fetch in the cycle LOAD is exited SHALL be refused (if_ready = 0); the first accepted fetch SHALL see all prior writes.
REQ-034 if_valid SHALL be 0 in any cycle that does not follow an accepted fetch; if_data SHALL hold its last value.

Reset
REQ-035 Asserting rst SHALL force, without a clock edge: state RUN, ptr 0, ld_ovf 0, if_valid 0, if_err 0, if_data NOP_WORD, busy 0, and all written bits 0.
REQ-036 Reset during LOAD SHALL abort the burst; all words SHALL read as NOP_WORD afterwards.
REQ-037 Memory array contents SHALL NOT be reset; only written bits are.

Structure
REQ-038 Package prog_mem_pkg SHALL hold the state encoding and the opcode constants NOP (8'h00) and HALT (8'hF0).
REQ-039 Sub-module prog_mem_loader SHALL contain the state machine, pointer, and ld_ovf; the array, written bits, and fetch port SHALL remain in prog_mem.

Verification
REQ-040 Load burst at base 0 of A3,91,A5,11,00,F0, then fetch addresses 0..5 back-to-back -> responses one cycle later, same order and values, if_valid high for 6 consecutive cycles.
REQ-041 Fetch addr 9 with no prior load -> if_data 00, if_err 0; fetch addr 300 with ADDR_W=9, DEPTH=256 -> if_data 00, if_err 1.
REQ-042 Load base 254 with 3 words 11,22,33 -> mem[254]=11, mem[255]=22, mem[0]=33, ld_ovf = 1 until the next ld_start.
REQ-043 if_req held high throughout a load -> if_ready 0 and busy 1 from ld_start to ld_done; no if_valid pulses.
REQ-044 rst asserted mid-burst after 2 writes -> busy and if_valid drop immediately; fetch addr 0 afterwards returns 00.
REQ-045 ld_valid with ld_done (data F0 at ptr 5) -> write committed, next-cycle fetch of 5 returns F0.
